seg_disp_arbiter: RTL
=====================

# seg_disp_arbiter

Display-ownership controller for the door-lock 6-digit seven-segment display. It arbitrates between the keypad-entry view, the change-password view and timed status messages (open / fail), and runs the failed-attempt lockout. It drives the source select, the `change` enable consumed by the change-mode display gate, and a per-digit enable mask for blinking. It sits between the lock FSM/keypad logic and the segment display blocks.

## Interface
- HOLD_CYC, 25_000_000, cycles a status message (open/fail) stays on screen
- BLINK_CYC, 12_500_000, half-period of blink in fail/lock views
- LOCK_CYC, 250_000_000, lockout duration after third consecutive failure
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_entry  in  1  level; keypad entry in progress
- req_change  in  1  level; change-password mode active
- evt_open  in  1  one-cycle pulse; correct password, door opens
- evt_fail  in  1  one-cycle pulse; wrong password
- sel  out  3  display source: 0 blank, 1 entry, 2 change, 3 open msg, 4 fail msg
- change_en  out  1  enable to the change-mode display gate
- digit_en  out  6  per-digit enable, bit0 = com3 … bit5 = com8
- busy  out  1  timed message or lockout in progress
- fail_cnt  out  2  consecutive failures, 0..3
- lock  out  1  lockout active

## Operation
- States: IDLE, ENTRY, CHANGE, MSG_OPEN, MSG_FAIL, LOCK.
- Arbitration each cycle outside MSG_*/LOCK, highest priority first: evt_fail, evt_open, req_change, req_entry, none → IDLE.
- State outputs:
  - IDLE: sel=0, digit_en=000000.
  - ENTRY: sel=1, digit_en=111111.
  - CHANGE: sel=2, change_en=1, digit_en=111111.
  - MSG_OPEN: sel=3, digit_en=111111, busy=1.
  - MSG_FAIL: sel=4, busy=1, digit_en blinks.
  - LOCK: sel=4, busy=1, lock=1, digit_en blinks.
- change_en=1 only in CHANGE.
- MSG_OPEN / MSG_FAIL:
  - Hold counter loaded on entry. Level requests are ignored while holding.
  - On expiry, re-arbitrate on the current levels.
- Events during a hold:
  - evt_fail in MSG_OPEN or MSG_FAIL goes to MSG_FAIL and restarts the hold.
  - evt_open in MSG_FAIL is discarded.
  - evt_open in MSG_OPEN restarts the hold.
- evt_open and evt_fail in the same cycle: fail wins, open is discarded everywhere.
- fail_cnt:
  - Increments on each accepted evt_fail; saturates at 3.
  - Cleared on accepted evt_open and on LOCK exit.
- The evt_fail that makes fail_cnt=3 goes directly to LOCK instead of MSG_FAIL.
- LOCK:
  - Lasts LOCK_CYC cycles; all events and requests ignored.
  - On exit: fail_cnt←0, then re-arbitrate on levels.
- Blink: digit_en=111111 on the first cycle of MSG_FAIL/LOCK, then toggles to 000000 / 111111 every BLINK_CYC cycles. The blink phase restarts on every entry or restart.

## Timing
- All outputs are registered and update on the same edge as the state; input sampled at edge k → outputs valid after edge k.
- Hold: entered at edge k, state left at edge k+HOLD_CYC, i.e. exactly HOLD_CYC cycles displayed. LOCK uses the same rule with LOCK_CYC.
- Counters are sized by $clog2 of the largest parameter. Down-counters are loaded with N-1; expiry is at 0, with no wrap past 0.
- Reset (async assert, any time, including mid-hold or mid-lock):
  - state=IDLE, sel=0, change_en=0, digit_en=000000, busy=0, fail_cnt=0, lock=0.
  - All counters are cleared.
- Release is synchronous to clk. The first arbitration happens at the first edge after rst goes high.
- Level inputs dropping during a hold have no effect until expiry.

## Test plan
Benches run with HOLD_CYC=8, BLINK_CYC=2, LOCK_CYC=16.
- Reset then req_entry=1 → sel=1, digit_en=111111 one edge later. Add req_change=1 → sel=2, change_en=1. Drop both → sel=0, digit_en=000000.
- req_entry=1, pulse evt_open → sel=3, busy=1 for exactly 8 cycles, then sel=1, busy=0, fail_cnt=0.
- Pulse evt_fail → sel=4, fail_cnt=1, digit_en pattern 111111,111111,000000,000000,… for 8 cycles. A second evt_fail at cycle 5 restarts the hold (8 more cycles) and sets fail_cnt=2. evt_open during that hold is ignored.
- Three evt_fail pulses → lock=1, sel=4 for 16 cycles, with evt_open/evt_fail ignored. Then lock=0, fail_cnt=0, sel follows levels.
- evt_open and evt_fail in the same cycle → sel=4, fail_cnt increments. A later evt_open → fail_cnt=0.
- Assert rst low mid-LOCK (cycle 7) → all outputs at reset values immediately. After release, req_entry=1 → sel=1.

Source files
------------

// File: rtl/seg_disp_arbiter.sv
// Display-ownership controller for the door-lock 6-digit seven-segment display.
// Arbitrates entry/change views against timed open/fail messages and runs the failed-attempt lockout.
module seg_disp_arbiter #(
  parameter int HOLD_CYC  = 25_000_000,
  parameter int BLINK_CYC = 12_500_000,
  parameter int LOCK_CYC  = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_entry,
  input  logic       req_change,
  input  logic       evt_open,
  input  logic       evt_fail,
  output logic [2:0] sel,
  output logic       change_en,
  output logic [5:0] digit_en,
  output logic       busy,
  output logic [1:0] fail_cnt,
  output logic       lock
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_CHANGE   = 3'd2;
  localparam logic [2:0] S_MSG_OPEN = 3'd3;
  localparam logic [2:0] S_MSG_FAIL = 3'd4;
  localparam logic [2:0] S_LOCK     = 3'd5;

  localparam int MAX_CYC = (HOLD_CYC > LOCK_CYC) ? HOLD_CYC : LOCK_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int BW      = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCK_CYC - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYC - 1);

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          phase_reg, phase_next;
  logic [1:0]    fail_reg, fail_next;

  logic [2:0] sel_reg, sel_next;
  logic       change_en_reg, change_en_next;
  logic       busy_reg, busy_next;
  logic       lock_reg, lock_next;
  logic [5:0] digit_reg, digit_mask_next;
  logic       digit_on_next;

  logic [2:0] level_state;
  logic [1:0] fail_inc;
  logic       take_fail;

  assign level_state = req_change ? S_CHANGE : (req_entry ? S_ENTRY : S_IDLE);
  assign fail_inc    = (fail_reg == 2'd3) ? 2'd3 : fail_reg + 2'd1;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    fail_next      = fail_reg;
    blink_cnt_next = blink_cnt_reg;
    phase_next     = phase_reg;
    take_fail      = 1'b0;

    case (state_reg)
      S_MSG_OPEN: begin
        if (evt_fail) begin
          take_fail = 1'b1;
        end else if (evt_open) begin
          cnt_next = HOLD_LOAD;
        end else if (cnt_reg == '0) begin
          state_next = level_state;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_MSG_FAIL: begin
        // evt_open is deliberately dropped while a failure is on screen
        if (evt_fail) begin
          take_fail = 1'b1;
        end else if (cnt_reg == '0) begin
          state_next = level_state;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_LOCK: begin
        if (cnt_reg == '0) begin
          fail_next  = 2'd0;
          state_next = level_state;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        if (evt_fail) begin
          take_fail = 1'b1;
        end else if (evt_open) begin
          state_next = S_MSG_OPEN;
          cnt_next   = HOLD_LOAD;
          fail_next  = 2'd0;
        end else begin
          state_next = level_state;
        end
      end
    endcase

    if (take_fail) begin
      fail_next      = fail_inc;
      phase_next     = 1'b1;
      blink_cnt_next = BLINK_LOAD;
      if (fail_inc == 2'd3) begin
        state_next = S_LOCK;
        cnt_next   = LOCK_LOAD;
      end else begin
        state_next = S_MSG_FAIL;
        cnt_next   = HOLD_LOAD;
      end
    end else if (state_reg == S_MSG_FAIL || state_reg == S_LOCK) begin
      if (blink_cnt_reg == '0) begin
        phase_next     = ~phase_reg;
        blink_cnt_next = BLINK_LOAD;
      end else begin
        blink_cnt_next = blink_cnt_reg - 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    sel_next       = 3'd0;
    change_en_next = 1'b0;
    busy_next      = 1'b0;
    lock_next      = 1'b0;
    digit_on_next  = 1'b0;
    case (state_next)
      S_ENTRY: begin
        sel_next      = 3'd1;
        digit_on_next = 1'b1;
      end
      S_CHANGE: begin
        sel_next       = 3'd2;
        change_en_next = 1'b1;
        digit_on_next  = 1'b1;
      end
      S_MSG_OPEN: begin
        sel_next      = 3'd3;
        busy_next     = 1'b1;
        digit_on_next = 1'b1;
      end
      S_MSG_FAIL: begin
        sel_next      = 3'd4;
        busy_next     = 1'b1;
        digit_on_next = phase_next;
      end
      S_LOCK: begin
        sel_next      = 3'd4;
        busy_next     = 1'b1;
        lock_next     = 1'b1;
        digit_on_next = phase_next;
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      assign digit_mask_next[gi] = digit_on_next;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      fail_reg      <= 2'd0;
      sel_reg       <= 3'd0;
      change_en_reg <= 1'b0;
      busy_reg      <= 1'b0;
      lock_reg      <= 1'b0;
      digit_reg     <= 6'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
      fail_reg      <= fail_next;
      sel_reg       <= sel_next;
      change_en_reg <= change_en_next;
      busy_reg      <= busy_next;
      lock_reg      <= lock_next;
      digit_reg     <= digit_mask_next;
    end
  end

  assign sel       = sel_reg;
  assign change_en = change_en_reg;
  assign busy      = busy_reg;
  assign lock      = lock_reg;
  assign digit_en  = digit_reg;
  assign fail_cnt  = fail_reg;

endmodule
